fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the fetch stage (PC plus instruction memory) and the decode stage of the pipelined CPU.
- Fetch pushes {pc, instr} pairs; decode pops them with a valid/ready handshake.
- Decouples fetch from decode stalls; a branch/jump redirect empties it in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, 32, width of stored PC
- DATA_W, 32, width of stored instruction word

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous active-low reset
- flush_i  input  1  discard all entries (branch/jump redirect)
- push_valid_i  input  1  fetch presents an entry
- push_ready_o  output  1  queue accepts an entry this cycle
- push_pc_i  input  ADDR_W  PC of fetched instruction
- push_instr_i  input  DATA_W  fetched instruction word
- pop_valid_o  output  1  head entry available to decode
- pop_ready_i  input  1  decode consumes head this cycle
- pop_pc_o  output  ADDR_W  PC of head entry
- pop_instr_o  output  DATA_W  instruction of head entry
- count_o  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_i low, asynchronous): read pointer, write pointer and count go to 0; pop_valid_o=0; push_ready_o=0 while reset is asserted; count_o=0. Storage array is not reset.
- Push handshake: push_valid_i & push_ready_o at a rising edge writes the entry at the write pointer, and the write pointer increments.
- Pop handshake: pop_valid_o & pop_ready_i at a rising edge increments the read pointer.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate count register.
- push_ready_o = (count != DEPTH) & ~flush_i.
  - Does not depend on pop_ready_i: no push into a full queue even when a pop occurs in the same cycle.
- pop_valid_o = (count != 0) & ~flush_i.
- pop_pc_o / pop_instr_o = storage at the read pointer when pop_valid_o=1; all zeros when pop_valid_o=0.
- Latency: an entry pushed at edge N is visible at pop at edge N (after the edge), i.e. usable in the next cycle. Minimum push-to-pop is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count=DEPTH): push_ready_o=0, push stalls. A pop frees a slot from the following cycle.
- Empty (count=0): pop_valid_o=0, pop_ready_i is ignored.
- Flush: at the edge with flush_i=1, both pointers and count go to 0.
  - Push and pop are both masked in that cycle, so no handshake completes.
  - Flush has priority over all other activity.
- count_o = count register, always in 0..DEPTH.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- Reset asserted mid-operation: queue empties immediately, independent of the clock.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN
- Defined: when count=0, push_valid_i=1 and flush_i=0:
  - pop_valid_o=1 combinationally, with pop_pc_o/pop_instr_o = push_pc_i/push_instr_i.
  - If pop_ready_i=1, the entry is consumed without being written and count stays 0.
  - If pop_ready_i=0, the entry is written normally.
  - Zero-cycle latency when empty.
- Not defined: no combinational path from push to pop; minimum latency is 1 cycle.

Decomposition:
- Shared CPU package:
  - ADDR_W/DATA_W defaults (32).
  - A fetch-entry struct {pc, instr} also used by the IF/ID register.
- One natural sub-module: fetch_queue_mem, the DEPTH x (ADDR_W+DATA_W) register array.
  - One write port, one asynchronous read port.
  - No reset.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
- Reset then idle: rst_i low mid-cycle -> count_o=0, pop_valid_o=0 immediately. After release, push_ready_o=1.
- Fill/drain: push pc 0x00,0x04,0x08,0x0C with pop_ready_i=0 -> count_o=4, push_ready_o=0. Then pop_ready_i=1 -> pops in order 0x00..0x0C, count 3,2,1,0.
- Full with simultaneous pop: count=4, push_valid_i=1, pop_ready_i=1 -> pop completes, push does not, count=3. Next cycle push accepted, count=4.
- Wrap-around: stream 10 entries (pc 0x00..0x24) with pop_ready_i=1 every cycle -> pop order identical to push order, no loss across pointer wrap.
- Flush: count=3, flush_i=1 with push_valid_i=1 and pop_ready_i=1 -> no handshake that cycle. Next cycle count_o=0, pop_valid_o=0, outputs zero. A new push of pc 0x40 pops first.
- Bypass (FETCH_QUEUE_BYPASS_EN defined): empty queue, push pc 0x80 with pop_ready_i=1 -> pop_pc_o=0x80 in the same cycle, count_o stays 0. Without the macro -> pop_valid_o=0 that cycle, and pc 0x80 pops next cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared CPU front-end types: default datapath widths and the fetch entry {pc, instr}
// carried by the fetch queue and the IF/ID register.
package fetch_queue_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x WIDTH register array, one write port, one asynchronous
// read port. Contents are deliberately not reset.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: store the accepted entry at the write pointer
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode with single-cycle flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: empty-queue push is forwarded to pop in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [ADDR_W-1:0]          push_pc_i,
    input  logic [DATA_W-1:0]          push_instr_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [ADDR_W-1:0]          pop_pc_o,
    output logic [DATA_W-1:0]          pop_instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             push_ready_s;
    logic             pop_valid_s;
    logic             bypass_s;
    logic             wr_en_s;
    logic             rd_adv_s;
    logic [ENT_W-1:0] mem_rdata_s;
    logic [ENT_W-1:0] head_s;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i (clk_i),
        .we    (wr_en_s),
        .waddr (wr_ptr_r),
        .wdata ({push_pc_i, push_instr_i}),
        .raddr (rd_ptr_r),
        .rdata (mem_rdata_s)
    );

    // Handshake qualification; rst_i gating keeps ready low for the whole reset window
    always_comb begin
        push_ready_s = rst_i & (count_r != CNT_W'(DEPTH)) & ~flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s     = rst_i & (count_r == {CNT_W{1'b0}}) & push_valid_i & ~flush_i;
`else
        bypass_s     = 1'b0;
`endif
        pop_valid_s  = (rst_i & (count_r != {CNT_W{1'b0}}) & ~flush_i) | bypass_s;
        if (bypass_s) begin
            head_s = {push_pc_i, push_instr_i};
        end else begin
            head_s = mem_rdata_s;
        end
        // A bypassed entry taken by decode never lands in storage
        wr_en_s  = push_valid_i & push_ready_s & ~(bypass_s & pop_ready_i);
        rd_adv_s = pop_valid_s & pop_ready_i & ~bypass_s;
    end

    // Head presentation: zeroed whenever nothing is valid
    always_comb begin
        pop_valid_o  = pop_valid_s;
        push_ready_o = push_ready_s;
        count_o      = count_r;
        if (pop_valid_s) begin
            pop_pc_o    = head_s[ENT_W-1:DATA_W];
            pop_instr_o = head_s[DATA_W-1:0];
        end else begin
            pop_pc_o    = {ADDR_W{1'b0}};
            pop_instr_o = {DATA_W{1'b0}};
        end
    end

    // Pointer and occupancy state; flush wins over any handshake in the same cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, rd_adv_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed test-plan sequences followed by random traffic,
// checked against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i        = 1'b0;
    logic        rst_i        = 1'b0;
    logic        flush_i      = 1'b0;
    logic        push_valid_i = 1'b0;
    logic        pop_ready_i  = 1'b0;
    logic [31:0] push_pc_i    = 32'h0;
    logic [31:0] push_instr_i = 32'h0;
    logic        push_ready_o;
    logic        pop_valid_o;
    logic [31:0] pop_pc_o;
    logic [31:0] pop_instr_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;
    fetch_entry_t exp_q[$];
    int pre_size = 0;
    logic exp_v;
    fetch_entry_t head_e;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_pc_i    (push_pc_i),
        .push_instr_i (push_instr_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .pop_pc_o     (pop_pc_o),
        .pop_instr_o  (pop_instr_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predictor: checks occupancy/ready against the model and records accepted pushes
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("rst_count", 64'(count_o), 64'd0);
            chk("rst_push_ready", 64'(push_ready_o), 64'd0);
            exp_q.delete();
            pre_size = 0;
        end else begin
            pre_size = exp_q.size();
            chk("count", 64'(count_o), 64'(pre_size));
            chk("push_ready", 64'(push_ready_o), 64'(pre_size < DEPTH && !flush_i));
            if (flush_i) exp_q.delete();
            else if (push_valid_i && pre_size < DEPTH)
                exp_q.push_back('{pc: push_pc_i, instr: push_instr_i});
        end
    end

    // Monitor: compares the presented head and retires it on a pop handshake
    always @(negedge clk_i) begin
        #2;
        exp_v = rst_i && !flush_i && (pre_size > 0 || (BYP && push_valid_i));
        chk("pop_valid", 64'(pop_valid_o), 64'(exp_v));
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL model_empty actual=valid expected=no entry at %0t", $time);
            end else begin
                head_e = exp_q[0];
                chk("pop_pc", 64'(pop_pc_o), 64'(head_e.pc));
                chk("pop_instr", 64'(pop_instr_o), 64'(head_e.instr));
                if (pop_ready_i) void'(exp_q.pop_front());
            end
        end else begin
            chk("pop_pc_zero", 64'(pop_pc_o), 64'd0);
            chk("pop_instr_zero", 64'(pop_instr_o), 64'd0);
        end
    end

    task automatic cyc(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
        push_valid_i = pv;
        push_pc_i    = pc;
        push_instr_i = pc ^ 32'hA5A5_0000;
        pop_ready_i  = pr;
        flush_i      = fl;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Fill then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Full with simultaneous pop: pop completes, push waits a cycle
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h10, 1'b1, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(i * 4), 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with push and pop requested in the same cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h100 + i * 4), 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 1'b1, 1'b1);
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Push into an empty queue with decode ready
        push_valid_i = 1'b1;
        push_pc_i    = 32'h80;
        push_instr_i = 32'h80 ^ 32'hA5A5_0000;
        pop_ready_i  = 1'b1;
        flush_i      = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("bypass_valid", 64'(pop_valid_o), 64'd1);
        chk("bypass_pc", 64'(pop_pc_o), 64'h80);
`else
        chk("nobypass_valid", 64'(pop_valid_o), 64'd0);
`endif
        @(posedge clk_i);
        #1;
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with entries held
        for (int i = 0; i < 2; i++) cyc(1'b1, 32'(32'h300 + i * 4), 1'b0, 1'b0);
        push_valid_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_count", 64'(count_o), 64'd0);
        chk("async_rst_pop_valid", 64'(pop_valid_o), 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 70), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 4));
        end
        repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
